// File: rtl/burst_sdr_if.sv
// burst_sdr_if: signal bundle between the cartridge register decoder, the CNT/SP pads and burst_sdr.
// Ports: slave modport = the serial port (takes strobes/pad inputs, drives status/pad drivers);
//        master modport = the host/pad side (the mirror image).
interface burst_sdr_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
);
  logic             mode;
  logic [DIV_W-1:0] div;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             clr_ovr;
  logic             cnt_in;
  logic             sp_in;
  logic             cnt_out;
  logic             cnt_oe;
  logic             sp_out;
  logic             sp_oe;
  logic             tx_full;
  logic             tx_empty;
  logic             rx_empty;
  logic             rx_full;
  logic             busy;
  logic             irq;
  logic             overrun;

  modport slave (
    input  mode, div, wr_en, wr_data, rd_en, clr_ovr, cnt_in, sp_in,
    output rd_data, cnt_out, cnt_oe, sp_out, sp_oe,
    output tx_full, tx_empty, rx_empty, rx_full, busy, irq, overrun
  );

  modport master (
    output mode, div, wr_en, wr_data, rd_en, clr_ovr, cnt_in, sp_in,
    input  rd_data, cnt_out, cnt_oe, sp_out, sp_oe,
    input  tx_full, tx_empty, rx_empty, rx_full, busy, irq, overrun
  );
endinterface

// File: rtl/burst_sdr.sv
// burst_sdr: buffered CIA-style serial data port; TX/RX FIFOs, programmable CNT bit clock, burst streaming.
// Ports: E_CLK/RESET (async, active-high) plain; everything else through burst_sdr_if.slave.
// Build option BURST_SDR_LSB_FIRST_EN: shift LSB first in both directions (default MSB first).

// Small show-ahead FIFO: registered pointers plus count, push-when-full and pop-when-empty ignored.
module burst_sdr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop_ok) r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module burst_sdr #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DIV_W = 8
) (
  input  logic         E_CLK,
  input  logic         RESET,
  burst_sdr_if.slave   bus
);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [DIV_W-1:0] r_hcnt, w_hcnt_nx;      // half-period down counter
  logic [BW-1:0]    r_bit, w_bit_nx;        // bits completed in current word
  logic             r_phase_hi, w_phase_nx; // TX: 0 = CNT low half, 1 = CNT high half
  logic [WIDTH-1:0] r_sh, w_sh_nx;
  logic             r_cnt_out, w_cnt_nx;
  logic             r_sp_out, w_sp_nx;
  logic             r_overrun, w_ovr_nx;
  logic             r_mode_d;
  logic             r_cnt_s1, r_cnt_s2, r_cnt_d;
  logic             r_sp_s1, r_sp_s2;

  logic             w_mode_chg;
  logic             w_cnt_rise;
  logic             w_tx_pop;
  logic             w_rx_push;
  logic [WIDTH-1:0] w_tx_head;
  logic             w_tx_empty;
  logic             w_tx_full;
  logic             w_rx_empty;
  logic             w_rx_full;

  // Bit that leaves/enters the shift register first, and the shift step itself.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
`ifdef BURST_SDR_LSB_FIRST_EN
    return w[0];
`else
    return w[WIDTH-1];
`endif
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
`ifdef BURST_SDR_LSB_FIRST_EN
    return {b, w[WIDTH-1:1]};
`else
    return {w[WIDTH-2:0], b};
`endif
  endfunction

  burst_sdr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(E_CLK), .rst(RESET),
    .i_push(bus.wr_en), .i_push_dat(bus.wr_data), .i_pop(w_tx_pop),
    .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  burst_sdr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(E_CLK), .rst(RESET),
    .i_push(w_rx_push), .i_push_dat(r_sh), .i_pop(bus.rd_en),
    .o_head(bus.rd_data), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  // Pad synchronisers run in both modes so the edge detector is settled before RX starts.
  // CNT resets high (its idle level) so reset release never looks like a rising edge.
  always_ff @(posedge E_CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt_s1 <= 1'b1;
      r_cnt_s2 <= 1'b1;
      r_cnt_d  <= 1'b1;
      r_sp_s1  <= 1'b0;
      r_sp_s2  <= 1'b0;
      r_mode_d <= 1'b0;
    end else begin
      r_cnt_s1 <= bus.cnt_in;
      r_cnt_s2 <= r_cnt_s1;
      r_cnt_d  <= r_cnt_s2;
      r_sp_s1  <= bus.sp_in;
      r_sp_s2  <= r_sp_s1;
      r_mode_d <= bus.mode;
    end
  end

  assign w_cnt_rise = r_cnt_s2 && !r_cnt_d;
  assign w_mode_chg = (bus.mode != r_mode_d);

  always_ff @(posedge E_CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_hcnt     <= '0;
      r_bit      <= '0;
      r_phase_hi <= 1'b0;
      r_sh       <= '0;
      r_cnt_out  <= 1'b1;
      r_sp_out   <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_hcnt     <= w_hcnt_nx;
      r_bit      <= w_bit_nx;
      r_phase_hi <= w_phase_nx;
      r_sh       <= w_sh_nx;
      r_cnt_out  <= w_cnt_nx;
      r_sp_out   <= w_sp_nx;
      r_overrun  <= w_ovr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_hcnt_nx  = r_hcnt;
    w_bit_nx   = r_bit;
    w_phase_nx = r_phase_hi;
    w_sh_nx    = r_sh;
    w_cnt_nx   = r_cnt_out;
    w_sp_nx    = r_sp_out;
    w_ovr_nx   = r_overrun;
    w_tx_pop   = 1'b0;
    w_rx_push  = 1'b0;

    if (bus.clr_ovr) w_ovr_nx = 1'b0;

    if (w_mode_chg) begin
      // Abort: drop the partial word, FIFOs untouched.
      w_state_nx = S_IDLE;
      w_bit_nx   = '0;
      w_phase_nx = 1'b0;
      w_hcnt_nx  = '0;
      w_cnt_nx   = 1'b1;
    end else if (bus.mode) begin
      case (r_state)
        // DONE shares IDLE's load path so a waiting word follows after exactly one gap cycle.
        S_IDLE, S_DONE: begin
          if (!w_tx_empty) begin
            w_tx_pop   = 1'b1;
            w_sp_nx    = first_bit(w_tx_head);
            w_sh_nx    = shift_in(w_tx_head, 1'b0);
            w_cnt_nx   = 1'b0;
            w_phase_nx = 1'b0;
            w_hcnt_nx  = bus.div;
            w_bit_nx   = '0;
            w_state_nx = S_SHIFT;
          end else begin
            w_cnt_nx   = 1'b1;
            w_state_nx = S_IDLE;
          end
        end
        S_SHIFT: begin
          if (r_hcnt != '0) begin
            w_hcnt_nx = r_hcnt - DIV_W'(1);
          end else if (!r_phase_hi) begin
            w_cnt_nx   = 1'b1;
            w_phase_nx = 1'b1;
            w_hcnt_nx  = bus.div;
          end else if (r_bit == BW'(WIDTH - 1)) begin
            w_phase_nx = 1'b0;
            w_state_nx = S_DONE;
          end else begin
            w_cnt_nx   = 1'b0;
            w_sp_nx    = first_bit(r_sh);
            w_sh_nx    = shift_in(r_sh, 1'b0);
            w_bit_nx   = r_bit + BW'(1);
            w_phase_nx = 1'b0;
            w_hcnt_nx  = bus.div;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end else begin
      w_cnt_nx = 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_cnt_rise) begin
            w_sh_nx    = shift_in(r_sh, r_sp_s2);
            w_bit_nx   = BW'(1);
            w_state_nx = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_cnt_rise) begin
            w_sh_nx = shift_in(r_sh, r_sp_s2);
            if (r_bit == BW'(WIDTH - 1)) begin
              w_bit_nx   = '0;
              w_state_nx = S_DONE;
            end else begin
              w_bit_nx = r_bit + BW'(1);
            end
          end
        end
        S_DONE: begin
          // A full FIFO drops the word; setting overrun overrides a same-cycle clear.
          if (w_rx_full) w_ovr_nx = 1'b1;
          else           w_rx_push = 1'b1;
          w_bit_nx   = '0;
          w_state_nx = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign bus.cnt_out  = r_cnt_out;
  assign bus.sp_out   = r_sp_out;
  assign bus.cnt_oe   = bus.mode;
  assign bus.sp_oe    = bus.mode;
  assign bus.tx_full  = w_tx_full;
  assign bus.tx_empty = w_tx_empty;
  assign bus.rx_full  = w_rx_full;
  assign bus.rx_empty = w_rx_empty;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.irq      = (r_state == S_DONE) && !w_mode_chg;
  assign bus.overrun  = r_overrun;
endmodule

// File: tb/tb_burst_sdr.sv
// tb_burst_sdr: directed + randomized bench for burst_sdr with a word/queue level reference model.
// Ports: none; instantiates burst_sdr_if and burst_sdr, drives E_CLK/RESET and the interface.
// Honours BURST_SDR_LSB_FIRST_EN for the expected bit order.
module tb_burst_sdr;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int DW = 8;

  logic E_CLK = 1'b0;
  logic RESET = 1'b1;

  burst_sdr_if #(.WIDTH(W), .DIV_W(DW)) bus ();

  burst_sdr #(.WIDTH(W), .DEPTH(D), .DIV_W(DW)) dut (
    .E_CLK(E_CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 E_CLK = ~E_CLK;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge E_CLK) cyc++;

  // Pad/status monitor, sampled on the falling clock edge.
  int       q_fall[$];
  int       q_rise[$];
  logic     q_bits[$];
  int       irq_cnt = 0;
  bit       tx_full_seen = 1'b0;
  int       txe_fall = -1;
  logic     prev_cnt = 1'b1;
  logic     prev_txe = 1'b1;

  always @(negedge E_CLK) begin
    if (bus.cnt_oe === 1'b1) begin
      if (prev_cnt === 1'b1 && bus.cnt_out === 1'b0) q_fall.push_back(cyc);
      if (prev_cnt === 1'b0 && bus.cnt_out === 1'b1) begin
        q_rise.push_back(cyc);
        q_bits.push_back(bus.sp_out);
      end
    end
    prev_cnt = bus.cnt_out;
    if (bus.irq === 1'b1) irq_cnt++;
    if (bus.tx_full === 1'b1) tx_full_seen = 1'b1;
    if (prev_txe === 1'b1 && bus.tx_empty === 1'b0 && txe_fall < 0) txe_fall = cyc;
    prev_txe = bus.tx_empty;
  end

  // Reference model state.
  logic [W-1:0] exp_w[$];
  logic [W-1:0] rx_q[$];
  logic         mod_ovr = 1'b0;

  // i-th bit on the wire for word w.
  function automatic logic model_bit(input logic [W-1:0] w, input int i);
`ifdef BURST_SDR_LSB_FIRST_EN
    return w[i];
`else
    return w[W-1-i];
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge E_CLK);
    #1;
  endtask

  task automatic clear_mon();
    q_fall.delete();
    q_rise.delete();
    q_bits.delete();
    irq_cnt      = 0;
    tx_full_seen = 1'b0;
    txe_fall     = -1;
  endtask

  task automatic write_word(input logic [W-1:0] w);
    bus.wr_en   = 1'b1;
    bus.wr_data = w;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(bus.busy === 1'b0 && bus.tx_empty === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(n < budget), 32'd1);
  endtask

  // Compares everything seen on CNT/SP against exp_w at the given divider.
  task automatic check_tx(input string tag, input int dv);
    int nb   = exp_w.size() * W;
    int tbad = 0;
    chk({tag, "_nbits"}, q_bits.size(), nb);
    chk({tag, "_irq"}, irq_cnt, exp_w.size());
    if (q_bits.size() == nb && q_rise.size() == nb && q_fall.size() == nb) begin
      for (int k = 0; k < exp_w.size(); k++) begin
        int rb = 0;
        for (int i = 0; i < W; i++) begin
`ifdef BURST_SDR_LSB_FIRST_EN
          rb = rb + (int'(q_bits[k*W+i]) << i);
`else
          rb = rb * 2 + int'(q_bits[k*W+i]);
`endif
        end
        chk({tag, "_word"}, rb, exp_w[k]);
      end
      for (int j = 0; j < nb; j++) begin
        if (q_rise[j] - q_fall[j] != dv + 1) tbad++;
        if (j > 0 && (q_fall[j] - q_fall[j-1]) != 2 * (dv + 1) + ((j % W == 0) ? 1 : 0)) tbad++;
      end
      chk({tag, "_timing_errs"}, tbad, 0);
    end
  endtask

  task automatic rx_send(input logic [W-1:0] w, input int half);
    for (int i = 0; i < W; i++) begin
      bus.cnt_in = 1'b0;
      bus.sp_in  = model_bit(w, i);
      repeat (half) tick();
      bus.cnt_in = 1'b1;
      repeat (half) tick();
    end
    repeat (6) tick();
    if (rx_q.size() < D) rx_q.push_back(w);
    else mod_ovr = 1'b1;
  endtask

  task automatic rx_read_all(input string tag);
    while (rx_q.size() > 0) begin
      chk({tag, "_rd_data"}, bus.rd_data, rx_q[0]);
      void'(rx_q.pop_front());
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
    end
    chk({tag, "_rx_empty"}, bus.rx_empty, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rw[5];
    logic [W-1:0] one_w;
    int           dv;
    int           n;

    bus.mode    = 1'b1;
    bus.div     = DW'(1);
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.clr_ovr = 1'b0;
    bus.cnt_in  = 1'b1;
    bus.sp_in   = 1'b0;
    RESET       = 1'b1;
    repeat (3) @(posedge E_CLK);
    #1;

    // Reset state with mode=1.
    chk("rst_cnt_out",  bus.cnt_out,  1'b1);
    chk("rst_sp_out",   bus.sp_out,   1'b0);
    chk("rst_tx_empty", bus.tx_empty, 1'b1);
    chk("rst_tx_full",  bus.tx_full,  1'b0);
    chk("rst_rx_empty", bus.rx_empty, 1'b1);
    chk("rst_irq",      bus.irq,      1'b0);
    chk("rst_overrun",  bus.overrun,  1'b0);
    chk("rst_busy",     bus.busy,     1'b0);
    chk("rst_rd_data",  bus.rd_data,  32'd0);
    chk("rst_cnt_oe",   bus.cnt_oe,   1'b1);
    RESET = 1'b0;
    repeat (2) tick();

    // Single word 0xA5 at div=1.
    clear_mon();
    exp_w = {8'hA5};
    write_word(8'hA5);
    wait_idle("a5", 300);
    check_tx("a5", 1);
    if (q_fall.size() > 0) chk("a5_first_fall_latency", q_fall[0] - txe_fall, 1);
    chk("a5_busy", bus.busy, 1'b0);

    // Back-to-back burst.
    clear_mon();
    exp_w = {8'h12, 8'h34, 8'h56};
    write_word(8'h12);
    write_word(8'h34);
    write_word(8'h56);
    wait_idle("burst", 600);
    check_tx("burst", 1);
    chk("burst_tx_full_seen", tx_full_seen, 1'b0);

    // Random burst at a random divider.
    dv = $urandom_range(0, 3);
    bus.div = DW'(dv);
    clear_mon();
    exp_w.delete();
    for (int i = 0; i < 3; i++) exp_w.push_back(W'($urandom));
    for (int i = 0; i < 3; i++) write_word(exp_w[i]);
    wait_idle("rnd_burst", 1000);
    check_tx("rnd_burst", dv);

    // Bit order: 0x01.
    bus.div = DW'(1);
    clear_mon();
    one_w = W'(1);
    exp_w = {one_w};
    write_word(one_w);
    wait_idle("one", 300);
    check_tx("one", 1);
    if (q_bits.size() > 0) chk("one_first_bit", q_bits[0], model_bit(one_w, 0));

    // Fill TX FIFO in RX mode: fifth push is ignored.
    bus.mode = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) rw[i] = W'($urandom);
    for (int i = 0; i < 5; i++) write_word(rw[i]);
    chk("fill_tx_full", bus.tx_full, 1'b1);
    chk("fill_busy", bus.busy, 1'b0);

    // Abort after 3 TX bits.
    clear_mon();
    bus.mode = 1'b1;
    n = 0;
    while (q_rise.size() < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("abort_reach_3_bits", 32'(n < 200), 32'd1);
    bus.mode = 1'b0;
    tick();
    chk("abort_cnt_oe", bus.cnt_oe, 1'b0);
    chk("abort_sp_oe",  bus.sp_oe,  1'b0);
    repeat (10) tick();
    chk("abort_irq", irq_cnt, 0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_tx_empty", bus.tx_empty, 1'b0);

    // Remaining entries (rw[1..3]) are intact and go out once TX resumes.
    clear_mon();
    exp_w = {rw[1], rw[2], rw[3]};
    bus.mode = 1'b1;
    tick();
    wait_idle("resume", 1000);
    check_tx("resume", 1);

    // Reset mid-shift takes effect immediately.
    write_word(8'hFF);
    repeat (5) tick();
    chk("mid_busy_before", bus.busy, 1'b1);
    #2;
    RESET = 1'b1;
    #1;
    chk("mid_rst_cnt_out",  bus.cnt_out,  1'b1);
    chk("mid_rst_busy",     bus.busy,     1'b0);
    chk("mid_rst_tx_empty", bus.tx_empty, 1'b1);
    tick();
    RESET = 1'b0;
    tick();

    // RX: five words into a four-deep FIFO.
    bus.mode = 1'b0;
    repeat (2) tick();
    clear_mon();
    for (int i = 1; i <= 5; i++) rx_send(W'(i), 4);
    chk("rx_irq_count", irq_cnt, 5);
    chk("rx_full",      bus.rx_full,  32'(rx_q.size() == D));
    chk("rx_overrun",   bus.overrun,  mod_ovr);
    chk("rx_not_empty", bus.rx_empty, 1'b0);
    rx_read_all("rx");
    chk("rx_overrun_held", bus.overrun, 1'b1);
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    mod_ovr = 1'b0;
    chk("rx_overrun_cleared", bus.overrun, mod_ovr);

    // RX: random words at random CNT half-periods.
    for (int i = 0; i < 3; i++) rx_send(W'($urandom), $urandom_range(3, 6));
    chk("rx_rnd_overrun", bus.overrun, mod_ovr);
    rx_read_all("rx_rnd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
